ysyx_22040750_if_queue: RTL and testbench

Parametrised successor to the single-entry fetch/PC stage.
- Drives the instruction-memory request channel with up to MAX_OUTSTANDING in-order requests in flight.
- Buffers returned {pc, inst} pairs in a DEPTH-entry queue that feeds IF_ID.
- Supports redirects (branch, fence.i, trap): flushes the queue and silently drops stale in-flight responses.
- Sits between the next-PC logic / ICache port and the IF_ID pipeline register.

---
 rtl/ysyx_22040750_if_pkg.sv | 20 ++
 rtl/ysyx_22040750_sync_fifo.sv | 65 ++++++
 rtl/ysyx_22040750_if_queue.sv | 157 +++++++++++++++
 tb/tb_ysyx_22040750_if_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040750_if_pkg.sv
// Shared defaults, entry type and width helper for the fetch queue.
package ysyx_22040750_if_pkg;

  localparam logic [31:0] IFQ_PC_RESET = 32'h3000_0000;
  localparam int unsigned IFQ_PC_STEP  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/ysyx_22040750_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, synchronous clear and occupancy count.
module ysyx_22040750_sync_fifo
  import ysyx_22040750_if_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [clog2(DEPTH+1)-1:0]  o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_wrap_diff;
  logic          w_do_push;
  logic          w_do_pop;

  // Index wraps at DEPTH-1 so non-power-of-2 depths keep the wrap-bit scheme.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], AW'(0)};
    return {p[AW], p[AW-1:0] + AW'(1)};
  endfunction

  assign w_wr_idx    = r_wr_ptr[AW-1:0];
  assign w_rd_idx    = r_rd_ptr[AW-1:0];
  assign w_wrap_diff = r_wr_ptr[AW] != r_rd_ptr[AW];

  assign o_empty = r_wr_ptr == r_rd_ptr;
  assign o_full  = w_wrap_diff && (w_wr_idx == w_rd_idx);
  assign o_count = w_wrap_diff ? CW'(DEPTH) - CW'(w_rd_idx) + CW'(w_wr_idx)
                               : CW'(w_wr_idx) - CW'(w_rd_idx);
  assign o_rdata = r_mem[w_rd_idx];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[w_wr_idx] <= i_wdata;
  end

endmodule

// File: rtl/ysyx_22040750_if_queue.sv
// Multi-outstanding instruction fetch stage with a {pc, inst} queue toward IF_ID.
// Optional same-cycle response bypass when YSYX_22040750_IFQ_BYPASS_EN is defined.
module ysyx_22040750_if_queue
  import ysyx_22040750_if_pkg::*;
#(
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       INST_W          = 32,
  parameter int unsigned       DEPTH           = 4,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] PC_RESET        = ADDR_W'(IFQ_PC_RESET),
  parameter int unsigned       PC_STEP         = IFQ_PC_STEP
) (
  input  logic                                   I_sys_clk,
  input  logic                                   I_rst,
  input  logic                                   I_redirect,
  input  logic [ADDR_W-1:0]                      I_redirect_pc,
  output logic                                   O_req_valid,
  output logic [ADDR_W-1:0]                      O_req_addr,
  input  logic                                   I_req_ready,
  input  logic                                   I_rsp_valid,
  input  logic [INST_W-1:0]                      I_rsp_inst,
  output logic                                   O_IF_valid,
  output logic [ADDR_W-1:0]                      O_pc,
  output logic [INST_W-1:0]                      O_inst,
  input  logic                                   I_IF_ID_allowin,
  output logic [clog2(MAX_OUTSTANDING+1)-1:0]    O_outstanding
);

  localparam int unsigned OW  = clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QCW = clog2(DEPTH + 1);
  localparam int unsigned PCW = clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned EW  = ADDR_W + INST_W;

  logic              r_en;
  logic [ADDR_W-1:0] r_pc;
  logic [OW-1:0]     r_outstanding;
  logic [OW-1:0]     r_drop_cnt;

  logic              w_clr;
  logic              w_req_fire;
  logic              w_rsp_legal;
  logic              w_rsp_drop;
  logic              w_rsp_live;
  logic              w_bypass;

  logic [ADDR_W-1:0] w_pend_pc;
  logic              w_pend_full;
  logic              w_pend_empty;
  logic [PCW-1:0]    w_pend_count;

  logic              w_q_push;
  logic              w_q_pop;
  logic [EW-1:0]     w_q_head;
  logic              w_q_full;
  logic              w_q_empty;
  logic [QCW-1:0]    w_q_count;

  assign w_clr       = I_rst || I_redirect;
  assign w_req_fire  = O_req_valid && I_req_ready;
  assign w_rsp_legal = I_rsp_valid && (r_outstanding != '0);
  assign w_rsp_drop  = w_rsp_legal && (r_drop_cnt != '0);
  assign w_rsp_live  = w_rsp_legal && (r_drop_cnt == '0) && !I_redirect;

`ifdef YSYX_22040750_IFQ_BYPASS_EN
  assign w_bypass = w_q_empty && w_rsp_live && I_IF_ID_allowin;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_q_push = w_rsp_live && !w_bypass;
  assign w_q_pop  = !w_q_empty && I_IF_ID_allowin;

  // Credit: every in-flight request (stale ones included) reserves a queue slot.
  assign O_req_valid = r_en && !I_redirect
                    && (32'(r_outstanding) < MAX_OUTSTANDING)
                    && (32'(r_outstanding) + 32'(w_q_count) < DEPTH);
  assign O_req_addr    = r_pc;
  assign O_outstanding = r_outstanding;

  always_comb begin
    O_IF_valid = !w_q_empty;
    O_pc       = '0;
    O_inst     = '0;
    if (!w_q_empty) begin
      {O_pc, O_inst} = w_q_head;
    end
`ifdef YSYX_22040750_IFQ_BYPASS_EN
    else if (w_bypass) begin
      O_IF_valid = 1'b1;
      O_pc       = w_pend_pc;
      O_inst     = I_rsp_inst;
    end
`endif
  end

  // r_outstanding counts every in-flight request; r_drop_cnt is the stale subset,
  // so the live part (outstanding - drop_cnt) always matches the pending-PC FIFO.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_en          <= 1'b0;
      r_pc          <= PC_RESET;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_en          <= 1'b1;
      r_outstanding <= r_outstanding + OW'(w_req_fire) - OW'(w_rsp_legal);
      if (I_redirect) begin
        r_pc       <= I_redirect_pc;
        r_drop_cnt <= r_outstanding - OW'(w_rsp_legal);
      end else begin
        if (w_req_fire) r_pc       <= r_pc + ADDR_W'(PC_STEP);
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - OW'(1);
      end
    end
  end

  ysyx_22040750_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_fifo (
    .i_clk   (I_sys_clk),
    .i_clr   (w_clr),
    .i_push  (w_req_fire),
    .i_wdata (r_pc),
    .i_pop   (w_rsp_live),
    .o_rdata (w_pend_pc),
    .o_full  (w_pend_full),
    .o_empty (w_pend_empty),
    .o_count (w_pend_count)
  );

  ysyx_22040750_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .i_clk   (I_sys_clk),
    .i_clr   (w_clr),
    .i_push  (w_q_push),
    .i_wdata ({w_pend_pc, I_rsp_inst}),
    .i_pop   (w_q_pop),
    .o_rdata (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  always_ff @(posedge I_sys_clk) begin
    if (!I_rst) begin
      assert (!(I_rsp_valid && (r_outstanding == '0)));
      assert (!(w_q_push && w_q_full));
      assert (!(w_req_fire && w_pend_full));
      assert (!(w_rsp_live && w_pend_empty));
      assert (32'(w_pend_count) + 32'(r_drop_cnt) == 32'(r_outstanding));
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_if_queue.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_ysyx_22040750_if_queue;
  import ysyx_22040750_if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h3000_0000;
  localparam int unsigned QD = 4;
  localparam int unsigned MO = 2;
`ifdef YSYX_22040750_IFQ_BYPASS_EN
  localparam logic [31:0] LAT0 = 32'd1;
`else
  localparam logic [31:0] LAT0 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst, redirect, req_ready, rsp_valid, allowin;
  logic [31:0] redirect_pc, rsp_inst;
  logic        req_valid, if_valid;
  logic [31:0] req_addr, pc, inst;
  logic [1:0]  outstanding;

  always #5 clk = ~clk;

  ysyx_22040750_if_queue #(
    .DEPTH           (QD),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .I_sys_clk       (clk),
    .I_rst           (rst),
    .I_redirect      (redirect),
    .I_redirect_pc   (redirect_pc),
    .O_req_valid     (req_valid),
    .O_req_addr      (req_addr),
    .I_req_ready     (req_ready),
    .I_rsp_valid     (rsp_valid),
    .I_rsp_inst      (rsp_inst),
    .O_IF_valid      (if_valid),
    .O_pc            (pc),
    .O_inst          (inst),
    .I_IF_ID_allowin (allowin),
    .O_outstanding   (outstanding)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, rd; logic [31:0] rdpc; logic rdy, rv; logic [31:0] ri; logic aw;
    logic e_rv; logic [31:0] e_addr; logic e_ifv; logic [31:0] e_pc, e_inst; logic [1:0] e_out;
  } vec_t;
  vec_t tbl[21];

  function automatic vec_t mk(input logic a_rst, a_rd, input logic [31:0] a_rdpc,
                              input logic a_rdy, a_rv, input logic [31:0] a_ri, input logic a_aw,
                              input logic b_rv, input logic [31:0] b_addr, input logic b_ifv,
                              input logic [31:0] b_pc, b_inst, input logic [1:0] b_out);
    vec_t v;
    v.rst = a_rst; v.rd = a_rd; v.rdpc = a_rdpc; v.rdy = a_rdy; v.rv = a_rv; v.ri = a_ri; v.aw = a_aw;
    v.e_rv = b_rv; v.e_addr = b_addr; v.e_ifv = b_ifv; v.e_pc = b_pc; v.e_inst = b_inst; v.e_out = b_out;
    return v;
  endfunction

  // Reference model: ordered list of in-flight fetches (tagged stale after a
  // redirect), the expected IF_ID queue contents, and the fetch PC.
  typedef struct { logic [31:0] addr; logic stale; } fl_t;
  fl_t         fl[$];
  if_entry_t   m_q[$];
  logic [31:0] m_pc;
  logic        m_en;
  logic        g_hs, g_ifv, g_rqv;

  task automatic cyc(input logic t_rst, t_rd, input logic [31:0] t_rdpc,
                     input logic t_rdy, t_rv, input logic [31:0] t_ri, input logic t_aw);
    logic        e_rv, e_ifv, byp;
    logic [31:0] e_pc, e_inst;
    fl_t         f;
    rst = t_rst; redirect = t_rd; redirect_pc = t_rdpc;
    req_ready = t_rdy; rsp_valid = t_rv; rsp_inst = t_ri; allowin = t_aw;
    e_rv = m_en && !t_rd && (fl.size() < MO) && (fl.size() + m_q.size() < QD);
    byp  = 1'b0;
`ifdef YSYX_22040750_IFQ_BYPASS_EN
    byp = !t_rd && t_rv && (fl.size() > 0) && !fl[0].stale && (m_q.size() == 0) && t_aw;
`endif
    e_ifv  = (m_q.size() > 0) || byp;
    e_pc   = (m_q.size() > 0) ? m_q[0].pc   : (byp ? fl[0].addr : 32'd0);
    e_inst = (m_q.size() > 0) ? m_q[0].inst : (byp ? t_ri       : 32'd0);
    @(negedge clk);
    chk("req_valid",   32'(req_valid),   32'(e_rv));
    chk("req_addr",    req_addr,         m_pc);
    chk("if_valid",    32'(if_valid),    32'(e_ifv));
    chk("pc",          pc,               e_pc);
    chk("inst",        inst,             e_inst);
    chk("outstanding", 32'(outstanding), 32'(fl.size()));
    g_hs = req_valid && t_rdy; g_ifv = if_valid; g_rqv = req_valid;
    @(posedge clk); #1;
    if (t_rst) begin
      fl.delete(); m_q.delete(); m_pc = RST_PC; m_en = 1'b0;
    end else begin
      if (t_rd) begin
        if (t_rv) void'(fl.pop_front());
        foreach (fl[i]) fl[i].stale = 1'b1;
        m_q.delete();
        m_pc = t_rdpc;
      end else begin
        if ((m_q.size() > 0) && t_aw) void'(m_q.pop_front());
        if (t_rv) begin
          f = fl.pop_front();
          if (!f.stale && !byp) m_q.push_back('{pc: f.addr, inst: t_ri});
        end
        if (e_rv && t_rdy) begin
          fl.push_back('{addr: m_pc, stale: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      m_en = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((fl.size() > 0) || (m_q.size() > 0)) && (n < 50)) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b0, fl.size() > 0, $urandom, 1'b1);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL drain: queue not empty after %0d cycles, expected empty", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int hs_cnt;
    logic rd, rdy, rv, aw;
    logic [31:0] rp, ri;

    tbl[0]  = mk(1,0,0,0,0,0,0,                 0,RST_PC,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,0,0,0,                 0,RST_PC,0,0,0,0);
    tbl[2]  = mk(0,0,0,1,0,0,0,                 1,32'h30000000,0,0,0,0);
    tbl[3]  = mk(0,0,0,1,1,32'h3000FFFF,0,      1,32'h30000004,0,0,0,1);
    tbl[4]  = mk(0,0,0,1,1,32'h3000FFFB,1,      1,32'h30000008,1,32'h30000000,32'h3000FFFF,1);
    tbl[5]  = mk(0,0,0,0,1,32'h3000FFF7,1,      1,32'h3000000C,1,32'h30000004,32'h3000FFFB,1);
    tbl[6]  = mk(0,0,0,0,0,0,1,                 1,32'h3000000C,1,32'h30000008,32'h3000FFF7,0);
    tbl[7]  = mk(0,0,0,1,0,0,0,                 1,32'h3000000C,0,0,0,0);
    tbl[8]  = mk(0,0,0,1,0,0,0,                 1,32'h30000010,0,0,0,1);
    tbl[9]  = mk(0,0,0,1,0,0,0,                 0,32'h30000014,0,0,0,2);
    tbl[10] = mk(0,1,32'h80000000,1,0,0,0,      0,32'h30000014,0,0,0,2);
    tbl[11] = mk(0,0,0,1,1,32'hDEAD0001,0,      0,32'h80000000,0,0,0,2);
    tbl[12] = mk(0,0,0,1,1,32'hDEAD0002,0,      1,32'h80000000,0,0,0,1);
    tbl[13] = mk(0,0,0,0,1,32'h8000FFFF,0,      1,32'h80000004,0,0,0,1);
    tbl[14] = mk(0,0,0,0,0,0,1,                 1,32'h80000004,1,32'h80000000,32'h8000FFFF,0);
    tbl[15] = mk(0,0,0,1,0,0,0,                 1,32'h80000004,0,0,0,0);
    tbl[16] = mk(0,0,0,1,0,0,0,                 1,32'h80000008,0,0,0,1);
    tbl[17] = mk(0,1,32'h90000000,1,1,32'hBAD00004,0, 0,32'h8000000C,0,0,0,2);
    tbl[18] = mk(0,0,0,1,1,32'hBAD00008,0,      1,32'h90000000,0,0,0,1);
    tbl[19] = mk(0,0,0,0,1,32'h9000FFFF,0,      1,32'h90000004,0,0,0,1);
    tbl[20] = mk(0,0,0,0,0,0,1,                 1,32'h90000004,1,32'h90000000,32'h9000FFFF,0);

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_inst = '0; allowin = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; redirect = tbl[i].rd; redirect_pc = tbl[i].rdpc;
      req_ready = tbl[i].rdy; rsp_valid = tbl[i].rv; rsp_inst = tbl[i].ri; allowin = tbl[i].aw;
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), 32'(req_valid),   32'(tbl[i].e_rv));
      chk($sformatf("vec%0d_req_addr", i),  req_addr,         tbl[i].e_addr);
      chk($sformatf("vec%0d_if_valid", i),  32'(if_valid),    32'(tbl[i].e_ifv));
      chk($sformatf("vec%0d_pc", i),        pc,               tbl[i].e_pc);
      chk($sformatf("vec%0d_inst", i),      inst,             tbl[i].e_inst);
      chk($sformatf("vec%0d_out", i),       32'(outstanding), 32'(tbl[i].e_out));
      @(posedge clk); #1;
    end

    // Resynchronise the model with a plain reset.
    rst = 1'b1; redirect = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; allowin = 1'b0;
    @(posedge clk); #1;
    fl.delete(); m_q.delete(); m_pc = RST_PC; m_en = 1'b0;
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Response-to-IF_valid latency with an empty queue.
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    chk("latency_same_cycle", 32'(g_ifv), LAT0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("latency_next_cycle", 32'(g_ifv), 32'd1 - LAT0);
    drain();

    // Backpressure: IF_ID stalled for 20 cycles, queue fills to exactly DEPTH.
    hs_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      rv = fl.size() > 0;
      ri = rv ? (fl[0].addr ^ 32'h0000_FFFF) : 32'd0;
      cyc(1'b0, 1'b0, 32'd0, 1'b1, rv, ri, 1'b0);
      if (g_hs) hs_cnt++;
    end
    chk("bp_issued", 32'(hs_cnt), 32'(QD));
    chk("bp_req_valid_low", 32'(g_rqv), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("bp_pop_valid", 32'(g_ifv), 32'd1);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("bp_empty_after", 32'(g_ifv), 32'd0);
    drain();

    // Reset with 2 queued entries and 2 requests in flight.
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hA000_0001, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hA000_0002, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("pre_rst_hs", 32'(g_hs), 32'd1);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("post_rst_if_valid", 32'(g_ifv), 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("post_rst_first_req", 32'(g_hs), 32'd1);

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 600; i++) begin
      rd  = ($urandom_range(0, 15) == 0);
      rp  = $urandom & 32'hFFFF_FFFC;
      rdy = ($urandom_range(0, 1) == 1);
      rv  = (fl.size() > 0) && ($urandom_range(0, 2) != 0);
      aw  = ($urandom_range(0, 3) != 0);
      ri  = $urandom;
      cyc(1'b0, rd, rp, rdy, rv, ri, aw);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
